// File: rtl/scan_encoder_tx.sv
// PS/2 Set-2 keyboard emulator: maps a 6-bit key index to its make code and shifts
// code[, F0, code] out as device-to-host frames on ps2_clk/ps2_data.
module scan_encoder_tx #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP        = 8,
  parameter int unsigned EMIT_BREAK = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] DATA,
  input  logic       send,
  output logic       ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {StIdle, StShift, StGap, StDone} state_e;

  localparam int unsigned NumBytes = (EMIT_BREAK != 0) ? 3 : 1;
  localparam logic [1:0]  LastByte = 2'(NumBytes - 1);
  localparam logic [8:0]  BitLen   = 9'(2 * CLK_DIV);
  localparam logic [8:0]  HalfLen  = 9'(CLK_DIV);
  localparam logic [15:0] GapLen   = 16'(GAP);
  localparam logic [7:0]  BreakPfx = 8'hF0;

  // {mapped, code}; indices above 36 have no key.
  function automatic logic [8:0] key_map(input logic [5:0] idx);
    logic [8:0] m;
    m = 9'h000;
    case (idx)
      6'd0:  m = {1'b1, 8'h1C};
      6'd1:  m = {1'b1, 8'h32};
      6'd2:  m = {1'b1, 8'h21};
      6'd3:  m = {1'b1, 8'h23};
      6'd4:  m = {1'b1, 8'h24};
      6'd5:  m = {1'b1, 8'h2B};
      6'd6:  m = {1'b1, 8'h34};
      6'd7:  m = {1'b1, 8'h33};
      6'd8:  m = {1'b1, 8'h43};
      6'd9:  m = {1'b1, 8'h3B};
      6'd10: m = {1'b1, 8'h42};
      6'd11: m = {1'b1, 8'h4B};
      6'd12: m = {1'b1, 8'h3A};
      6'd13: m = {1'b1, 8'h31};
      6'd14: m = {1'b1, 8'h44};
      6'd15: m = {1'b1, 8'h4D};
      6'd16: m = {1'b1, 8'h15};
      6'd17: m = {1'b1, 8'h2D};
      6'd18: m = {1'b1, 8'h1B};
      6'd19: m = {1'b1, 8'h2C};
      6'd20: m = {1'b1, 8'h3C};
      6'd21: m = {1'b1, 8'h2A};
      6'd22: m = {1'b1, 8'h1D};
      6'd23: m = {1'b1, 8'h22};
      6'd24: m = {1'b1, 8'h35};
      6'd25: m = {1'b1, 8'h1A};
      6'd26: m = {1'b1, 8'h45};
      6'd27: m = {1'b1, 8'h16};
      6'd28: m = {1'b1, 8'h1E};
      6'd29: m = {1'b1, 8'h26};
      6'd30: m = {1'b1, 8'h25};
      6'd31: m = {1'b1, 8'h2E};
      6'd32: m = {1'b1, 8'h36};
      6'd33: m = {1'b1, 8'h3D};
      6'd34: m = {1'b1, 8'h3E};
      6'd35: m = {1'b1, 8'h46};
      6'd36: m = {1'b1, 8'h29};
      default: m = 9'h000;
    endcase
    return m;
  endfunction

  state_e      state_q, state_d;
  logic [8:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] gap_q, gap_d;
  logic [1:0]  byte_q, byte_d;
  logic [7:0]  code_q, code_d;
  logic        err_q, err_d;

  logic [8:0]  lookup;
  logic [7:0]  cur_byte;
  logic [10:0] frame;
  logic        accept, bit_end, frame_end, gap_end, advance;

  always_comb begin
    lookup   = key_map(DATA);
    accept   = send && (state_q == StIdle);
    cur_byte = (byte_q == 2'd1) ? BreakPfx : code_q;
    // Stop, odd parity, data LSB first, start.
    frame    = {1'b1, ~^cur_byte, cur_byte, 1'b0};
    bit_end   = (state_q == StShift) && (div_q == BitLen - 9'd1);
    frame_end = bit_end && (bit_q == 4'd10);
    gap_end   = (state_q == StGap) && (gap_q == GapLen - 16'd1);
    advance   = (frame_end && (GapLen == 16'd0)) || gap_end;
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    byte_d  = byte_q;
    code_d  = code_q;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (lookup[8]) begin
            code_d  = lookup[7:0];
            byte_d  = 2'd0;
            bit_d   = 4'd0;
            div_d   = 9'd0;
            state_d = StShift;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StShift: begin
        if (bit_end) begin
          div_d = 9'd0;
          if (frame_end) begin
            bit_d   = 4'd0;
            gap_d   = 16'd0;
            state_d = StGap;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          div_d = div_q + 9'd1;
        end
      end
      StGap: begin
        gap_d = gap_q + 16'd1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Shared end-of-byte handling, also covers a zero-length gap.
    if (advance) begin
      gap_d = 16'd0;
      if (byte_q == LastByte) begin
        state_d = StDone;
      end else begin
        byte_d  = byte_q + 2'd1;
        state_d = StShift;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      div_q   <= 9'd0;
      bit_q   <= 4'd0;
      gap_q   <= 16'd0;
      byte_q  <= 2'd0;
      code_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      byte_q  <= byte_d;
      code_q  <= code_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    ready    = (state_q == StIdle);
    ps2_clk  = !((state_q == StShift) && (div_q >= HalfLen));
    ps2_data = (state_q == StShift) ? frame[bit_q] : 1'b1;
    done     = (state_q == StDone);
    err      = err_q;
  end

endmodule

// File: doc/scan_encoder_tx.md
Name: scan_encoder_tx

Overview:
- Transmit-side counterpart of the scan-code decoder: takes a 6-bit key index on DATA and emits the PS/2 Set-2 byte sequence as a device-to-host serial stream.
- Default sequence is make code, then break prefix F0, then make code.
- Used as a keyboard emulator to drive the decoder path in loopback and bench setups.

Parameters:
- CLK_DIV, 4: clock cycles per ps2_clk half-period; legal range 2..255.
- GAP, 8: idle cycles, lines high, between consecutive bytes of one sequence.
- EMIT_BREAK, 1: 1 = send code, F0, code; 0 = send code only.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- DATA  in  6  key index; sampled only on an accepted request.
- send  in  1  request strobe; accepted when send=1 and ready=1.
- ready  out  1  high when idle and able to accept a request.
- ps2_clk  out  1  serial clock to the host; idles high.
- ps2_data  out  1  serial data to the host; idles high.
- done  out  1  one-cycle pulse after the last bit of the sequence plus its trailing gap.
- err  out  1  one-cycle pulse when a request carries an unmapped DATA value.

Behaviour:
- Reset (checked on the clock edge, overrides everything):
  - ready=1, ps2_clk=1, ps2_data=1, done=0, err=0, state=IDLE.
  - Counters cleared.
  - Reset mid-frame aborts the frame; lines read 1 from the next cycle and no done pulse is issued.
- Key map, DATA index to Set-2 code:
  - 0..25 = A..Z: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
  - 26..35 = digits 0..9: 45 16 1E 26 25 2E 36 3D 3E 46.
  - 36 = space: 29.
  - 37..63 are unmapped.
- Unmapped request:
  - err=1 on the cycle after acceptance; ready stays 1.
  - No line activity, no done pulse.
- Accepted mapped request:
  - DATA is latched; ready=0 from the next cycle.
  - The byte list is built as [code, F0, code], or [code] when EMIT_BREAK=0.
- States:
  - IDLE -> SHIFT on a valid accept.
  - SHIFT -> GAP after bit 10.
  - GAP -> SHIFT if bytes remain.
  - GAP -> DONE if the last byte has been sent.
  - DONE -> IDLE after one cycle.
- Frame format, 11 bits in this order:
  - start bit = 0;
  - data bits d0..d7, LSB first;
  - odd parity bit = 1 when the data byte has an even number of ones;
  - stop bit = 1.
- Bit timing:
  - Each bit lasts 2*CLK_DIV cycles.
  - ps2_data changes only at the start of a bit, while ps2_clk=1.
  - ps2_clk is 1 for the first CLK_DIV cycles of the bit and 0 for the next CLK_DIV cycles; the host samples on the falling edge.
  - The start bit is on ps2_data in the first cycle after acceptance.
  - One byte takes 22*CLK_DIV cycles.
  - After bit 10, ps2_clk=1 and ps2_data=1 for exactly GAP cycles; this gap also follows the last byte.
- done and ready:
  - done=1 for one cycle in DONE.
  - ready=1 from the cycle after done.
- Total latency from accept to done with EMIT_BREAK=1: 3*(22*CLK_DIV+GAP)+1 cycles.
- Simultaneous events:
  - send while ready=0 is ignored (no queueing, no err).
  - A send in the same cycle that ready returns high is accepted.
  - DATA changes after acceptance have no effect on the sequence in flight.

Test Plan:
- Reset, then DATA=0 (A) with one-cycle send, CLK_DIV=4, GAP=8:
  - Sampled on ps2_clk falling edges: 0,0,0,1,1,1,0,0,0,0,1 (byte 1C, parity 0).
  - Then 0,0,0,0,0,1,1,1,1,1,1 (F0, parity 1).
  - Then 1C again.
  - done pulses 3*(88+8)+1=289 cycles after accept.
- DATA=18 (S):
  - Byte 1B sent with parity 1.
  - Sequence 1B, F0, 1B.
  - Decoder-side loopback yields DATA=18.
- DATA=40:
  - err=1 for exactly one cycle.
  - ps2_clk and ps2_data stay 1; ready stays 1; no done.
- send=1 with DATA=5 held throughout the first byte:
  - Only one sequence is sent (2B, F0, 2B).
  - done pulses once.
  - Request re-accepted the cycle ready returns.
- reset=1 for one cycle during bit 4 of F0:
  - Next cycle: ps2_clk=1, ps2_data=1, ready=1.
  - No done; a new send is accepted normally.
- EMIT_BREAK=0, DATA=36 (space):
  - Single frame for 29, then done after 22*CLK_DIV+GAP+1 cycles.
